// File: rtl/pio_cfg_pkg.sv
// pio_cfg_pkg: shared types and constants for the PIO configuration sequencer.
//   - PIO action codes driven on the pio configuration bus
//   - pio_cfg_cmd_t: one stored configuration command
//   - pio_cfg_state_t: sequencer FSM states
// Optional feature macro: PIO_CFG_AUTO_ENABLE_EN (adds the ENABLE state).
package pio_cfg_pkg;

  // Action codes understood by the pio configuration bus.
  localparam logic [3:0] ACT_NONE   = 4'd0;
  localparam logic [3:0] ACT_INSTR  = 4'd1;
  localparam logic [3:0] ACT_WRAP   = 4'd2;
  localparam logic [3:0] ACT_ENABLE = 4'd6;
  localparam logic [3:0] ACT_CLKDIV = 4'd7;

  // Stored machine index is kept at a fixed generous width so the struct
  // does not depend on NUM_MACHINES; the top narrows it to MW bits.
  localparam int CMD_MW = 8;

  typedef struct packed {
    logic [3:0]        action;
    logic [CMD_MW-1:0] mindex;
    logic [4:0]        index;
    logic [31:0]       din;
  } pio_cfg_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FIN    = 2'd2
`ifdef PIO_CFG_AUTO_ENABLE_EN
    ,
    ENABLE = 2'd3
`endif
  } pio_cfg_state_t;

endpackage

// File: rtl/pio_cfg_buf.sv
// pio_cfg_buf: append-only command store for the configuration sequencer.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (empties the store)
//   wr_en/wr_cmd - append wr_cmd at position count (refused when full)
//   clr          - empty the store (wins over a simultaneous append)
//   rd_addr      - combinational read address, rd_cmd is the entry there
//   count        - number of stored commands (saturates at DEPTH)
//   full         - count == DEPTH
module pio_cfg_buf
  import pio_cfg_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  pio_cfg_cmd_t wr_cmd,
  input  logic         clr,
  input  logic [AW-1:0] rd_addr,
  output pio_cfg_cmd_t rd_cmd,
  output logic [CW-1:0] count,
  output logic         full
);

  pio_cfg_cmd_t  mem_r [DEPTH];
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          push_s;

  assign full_s = (count_r == CW'(DEPTH));
  assign push_s = wr_en && !full_s && !clr;

  // Fill level: cleared by reset or clr, incremented on an accepted append.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (push_s) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Entry storage; contents beyond count are don't-care so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[count_r[AW-1:0]] <= wr_cmd;
    end
  end

  assign rd_cmd = mem_r[rd_addr];
  assign count  = count_r;
  assign full   = full_s;

endmodule

// File: rtl/pio_cfg_seq.sv
// pio_cfg_seq: buffers PIO configuration commands and replays them onto the
// pio configuration bus, each held for HOLD_CYCLES cycles, back-to-back.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - host command write handshake
//   cmd_action/mindex/index/din - command fields to store
//   start                 - begin a replay of the stored list (pulse)
//   clear                 - empty the buffer / abort a running replay
//   enable_mask           - machines to enable after the list (macro only)
//   action/index/mindex/din - registered pio configuration bus
//   busy, done, count     - replay status and stored command count
// Optional feature macro: PIO_CFG_AUTO_ENABLE_EN appends an enable command
// (action 6, din = enable_mask) after every replay.
module pio_cfg_seq
  import pio_cfg_pkg::*;
#(
  parameter int NUM_MACHINES = 4,
  parameter int CMD_DEPTH    = 16,
  parameter int HOLD_CYCLES  = 2,
  localparam int MW = (NUM_MACHINES > 1) ? $clog2(NUM_MACHINES) : 1,
  localparam int AW = $clog2(CMD_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_action,
  input  logic [MW-1:0]           cmd_mindex,
  input  logic [4:0]              cmd_index,
  input  logic [31:0]             cmd_din,
  input  logic                    start,
  input  logic                    clear,
`ifdef PIO_CFG_AUTO_ENABLE_EN
  input  logic [NUM_MACHINES-1:0] enable_mask,
`endif
  output logic [3:0]              action,
  output logic [4:0]              index,
  output logic [MW-1:0]           mindex,
  output logic [31:0]             din,
  output logic                    busy,
  output logic                    done,
  output logic [CW-1:0]           count
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
`ifdef PIO_CFG_AUTO_ENABLE_EN
  localparam pio_cfg_state_t AFTER_LIST = ENABLE;
`else
  localparam pio_cfg_state_t AFTER_LIST = FIN;
`endif

  pio_cfg_state_t state_r, state_nxt_s;
  logic [AW-1:0]  ptr_r, ptr_nxt_s;
  logic [HW-1:0]  hold_r, hold_nxt_s;
  pio_cfg_cmd_t   wr_cmd_s, rd_cmd_s, bus_nxt_s;
  logic [CW-1:0]  count_s;
  logic           full_s, cmd_ready_s, wr_en_s, ptr_last_s;
  logic [MW-1:0]  mindex_nxt_s;
  logic [3:0]     action_r;
  logic [4:0]     index_r;
  logic [MW-1:0]  mindex_r;
  logic [31:0]    din_r;
  logic           busy_r, done_r;

  assign cmd_ready_s = !busy_r && !full_s && !start;
  assign wr_en_s     = cmd_valid && cmd_ready_s;
  assign wr_cmd_s    = '{action: cmd_action, mindex: CMD_MW'(cmd_mindex),
                         index: cmd_index, din: cmd_din};

  pio_cfg_buf #(.DEPTH(CMD_DEPTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_cmd  (wr_cmd_s),
    .clr     (clear),
    .rd_addr (ptr_nxt_s),
    .rd_cmd  (rd_cmd_s),
    .count   (count_s),
    .full    (full_s)
  );

  // count cannot change while replaying, so comparing against count-1 is safe.
  assign ptr_last_s = ({1'b0, ptr_r} == (count_s - CW'(1)));

  // Next-state, pointer and hold-counter logic; clear aborts from any state.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    hold_nxt_s  = hold_r;
    if (clear) begin
      state_nxt_s = IDLE;
      ptr_nxt_s   = '0;
      hold_nxt_s  = '0;
    end else begin
      case (state_r)
        IDLE: begin
          ptr_nxt_s  = '0;
          hold_nxt_s = '0;
          if (start) begin
            if (count_s != '0) begin
              state_nxt_s = ISSUE;
            end else begin
              state_nxt_s = AFTER_LIST;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ISSUE: begin
          if (hold_r == HOLD_LAST) begin
            hold_nxt_s = '0;
            if (ptr_last_s) begin
              state_nxt_s = AFTER_LIST;
            end else begin
              ptr_nxt_s = ptr_r + AW'(1);
            end
          end else begin
            hold_nxt_s = hold_r + HW'(1);
          end
        end
`ifdef PIO_CFG_AUTO_ENABLE_EN
        ENABLE: begin
          if (hold_r == HOLD_LAST) begin
            hold_nxt_s  = '0;
            state_nxt_s = FIN;
          end else begin
            hold_nxt_s = hold_r + HW'(1);
          end
        end
`endif
        FIN:     state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Bus value for the coming cycle; stored ACT_NONE entries become clean gaps.
  always_comb begin
    bus_nxt_s = '0;
    case (state_nxt_s)
      ISSUE: begin
        if (rd_cmd_s.action == ACT_NONE) begin
          bus_nxt_s = '0;
        end else begin
          bus_nxt_s = rd_cmd_s;
        end
      end
`ifdef PIO_CFG_AUTO_ENABLE_EN
      ENABLE: begin
        bus_nxt_s.action = ACT_ENABLE;
        bus_nxt_s.din    = 32'(enable_mask);
      end
`endif
      default: bus_nxt_s = '0;
    endcase
    // An out-of-range stored index is never forwarded to pio.
    if (bus_nxt_s.mindex > CMD_MW'(NUM_MACHINES - 1)) begin
      mindex_nxt_s = '0;
    end else begin
      mindex_nxt_s = bus_nxt_s.mindex[MW-1:0];
    end
  end

  // State, counters and registered bus/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      ptr_r    <= '0;
      hold_r   <= '0;
      action_r <= 4'd0;
      index_r  <= 5'd0;
      mindex_r <= '0;
      din_r    <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      hold_r   <= hold_nxt_s;
      action_r <= bus_nxt_s.action;
      index_r  <= bus_nxt_s.index;
      mindex_r <= mindex_nxt_s;
      din_r    <= bus_nxt_s.din;
      busy_r   <= (state_nxt_s != IDLE);
      done_r   <= (state_nxt_s == FIN);
    end
  end

  assign cmd_ready = cmd_ready_s;
  assign action    = action_r;
  assign index     = index_r;
  assign mindex    = mindex_r;
  assign din       = din_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign count     = count_s;

endmodule

// File: tb/tb_pio_cfg_seq.sv
// tb_pio_cfg_seq: directed self-checking bench for pio_cfg_seq with default
// parameters (4 machines, 16 entries, hold 2). Honours PIO_CFG_AUTO_ENABLE_EN.
module tb_pio_cfg_seq;

  localparam int HOLD = 2;
`ifdef PIO_CFG_AUTO_ENABLE_EN
  localparam int EN_CYC = HOLD;
`else
  localparam int EN_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_action = 4'd0;
  logic [1:0]  cmd_mindex = 2'd0;
  logic [4:0]  cmd_index = 5'd0;
  logic [31:0] cmd_din = 32'd0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  enable_mask = 4'b0101;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic        busy, done;
  logic [4:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  exp_a [16];
  logic [1:0]  exp_m [16];
  logic [4:0]  exp_i [16];
  logic [31:0] exp_d [16];

  pio_cfg_seq dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_action(cmd_action), .cmd_mindex(cmd_mindex), .cmd_index(cmd_index),
    .cmd_din(cmd_din), .start(start), .clear(clear),
`ifdef PIO_CFG_AUTO_ENABLE_EN
    .enable_mask(enable_mask),
`endif
    .action(action), .index(index), .mindex(mindex), .din(din),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int k, input logic [3:0] a, input logic [1:0] m,
                         input logic [4:0] i, input logic [31:0] d);
    exp_a[k] = a; exp_m[k] = m; exp_i[k] = i; exp_d[k] = d;
  endtask

  task automatic write_cmd(input logic [3:0] a, input logic [1:0] m,
                           input logic [4:0] i, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_action = a; cmd_mindex = m; cmd_index = i; cmd_din = d;
    tick;
    cmd_valid = 1'b0;
  endtask

  // Replays n stored commands and checks every bus cycle against exp_*;
  // a stray start mid-replay must be ignored.
  task automatic replay_check(input int n);
    int e;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < n * HOLD; k++) begin
      e = k / HOLD;
      chk("bus_action", action, exp_a[e]);
      chk("bus_mindex", mindex, exp_m[e]);
      chk("bus_index", index, exp_i[e]);
      chk("bus_din", din, exp_d[e]);
      chk("bus_busy", busy, 1);
      chk("bus_done", done, 0);
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
      tick;
    end
    for (int k = 0; k < EN_CYC; k++) begin
      chk("en_action", action, 6);
      chk("en_din", din, 32'(enable_mask));
      tick;
    end
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 1);
    chk("fin_action", action, 0);
    tick;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    int seen;
    tick; tick;
    reset = 1'b0;
    // Reset state.
    chk("rst_action", action, 0);
    chk("rst_index", index, 0);
    chk("rst_mindex", mindex, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", cmd_ready, 1);

    // Program load: 4 instructions, wrap, clkdiv, enable.
    set_exp(0, 4'd1, 2'd0, 5'd0, 32'hE081);
    set_exp(1, 4'd1, 2'd0, 5'd1, 32'hE101);
    set_exp(2, 4'd1, 2'd0, 5'd2, 32'hE000);
    set_exp(3, 4'd1, 2'd0, 5'd3, 32'h0001);
    set_exp(4, 4'd2, 2'd0, 5'd3, 32'h0000);
    set_exp(5, 4'd7, 2'd0, 5'd0, 32'h0280);
    set_exp(6, 4'd6, 2'd0, 5'd0, 32'h0001);
    for (int k = 0; k < 7; k++) write_cmd(exp_a[k], exp_m[k], exp_i[k], exp_d[k]);
    chk("load_count", count, 7);
    replay_check(7);
    chk("kept_count", count, 7);
    // Second replay must produce the same trace.
    replay_check(7);

    // start together with cmd_valid: command refused, replay begins.
    cmd_valid = 1'b1; cmd_action = 4'd1; cmd_index = 5'd9; cmd_din = 32'h1234;
    start = 1'b1;
    #1;
    chk("sv_ready", cmd_ready, 0);
    tick;
    cmd_valid = 1'b0; start = 1'b0;
    chk("sv_count", count, 7);
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      if (done) seen = 1;
      else tick;
    end
    chk("sv_done_seen", seen, 1);
    tick;
    chk("sv_idle", busy, 0);

    // Clear in IDLE, then abort an 8-command replay at cycle 3.
    clear = 1'b1; tick; clear = 1'b0;
    chk("clr_count", count, 0);
    for (int k = 0; k < 8; k++) write_cmd(4'd1, 2'd1, 5'(k), 32'h100 + 32'(k));
    chk("ab_count", count, 8);
    start = 1'b1; tick; start = 1'b0;
    chk("ab_first", din, 32'h100);
    tick; tick;
    clear = 1'b1; tick; clear = 1'b0;
    chk("ab_action", action, 0);
    chk("ab_busy", busy, 0);
    chk("ab_count0", count, 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) seen++;
      tick;
    end
    chk("ab_no_done", seen, 0);

    // Fill to capacity; 17th write refused and must not overwrite anything.
    for (int k = 0; k < 16; k++) begin
      set_exp(k, 4'd7, 2'(k % 4), 5'(k), 32'(k * 3 + 1));
      write_cmd(exp_a[k], exp_m[k], exp_i[k], exp_d[k]);
    end
    chk("full_count", count, 16);
    chk("full_ready", cmd_ready, 0);
    write_cmd(4'd1, 2'd3, 5'd31, 32'hDEAD);
    chk("full_sat", count, 16);
    replay_check(16);

    // Reset mid-replay empties the buffer and idles the bus.
    start = 1'b1; tick; start = 1'b0;
    tick; tick;
    reset = 1'b1; tick; reset = 1'b0;
    chk("mr_action", action, 0);
    chk("mr_din", din, 0);
    chk("mr_busy", busy, 0);
    chk("mr_count", count, 0);
    chk("mr_ready", cmd_ready, 1);

    // start with an empty buffer.
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < EN_CYC; k++) begin
      chk("emp_en_action", action, 6);
      chk("emp_en_din", din, 5);
      chk("emp_en_busy", busy, 1);
      tick;
    end
    chk("emp_done", done, 1);
    chk("emp_busy", busy, 1);
    chk("emp_action", action, 0);
    tick;
    chk("emp_done_low", done, 0);
    chk("emp_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_cfg_seq.md
# pio_cfg_seq

Parametrised configuration sequencer that stores a list of PIO configuration commands and replays them onto the `pio` configuration bus (`action`/`index`/`mindex`/`din`). The command list covers instruction loads, wrap, clock divider and enable, for any number of state machines. It replaces hand-sequenced bus writes with a buffered, repeatable, hardware-timed load. It sits between the host or boot logic and the `pio` block.

## Interface
Parameters:
- `NUM_MACHINES`, 4: number of state machines addressed. `MW = max(1, $clog2(NUM_MACHINES))`.
- `CMD_DEPTH`, 16: command buffer entries, power of two, ≥2.
- `HOLD_CYCLES`, 2: cycles each command is held on the bus, ≥1.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `cmd_valid`, in, 1: host offers a command.
- `cmd_ready`, out, 1: `!busy && !full && !start`.
- `cmd_action`, in, 4: action code.
- `cmd_mindex`, in, MW: machine index.
- `cmd_index`, in, 5: instruction or register index.
- `cmd_din`, in, 32: data.
- `start`, in, 1: begin replay (pulse).
- `clear`, in, 1: empty the buffer, or abort a replay.
- `enable_mask`, in, NUM_MACHINES: present only with `PIO_CFG_AUTO_ENABLE_EN`.
- `action`, out, 4: to `pio`.
- `index`, out, 5: to `pio`.
- `mindex`, out, MW: to `pio`.
- `din`, out, 32: to `pio`.
- `busy`, out, 1: replay in progress.
- `done`, out, 1: one-cycle pulse when a replay completes.
- `count`, out, $clog2(CMD_DEPTH)+1: number of stored commands.

## Operation
- Write: a command is stored when `cmd_valid && cmd_ready`, appended at `count`, and `count` increments.
- The buffer is retained after a replay, so a second `start` replays the same list.
- FSM states are `IDLE`, `ISSUE`, `ENABLE` (macro only) and `FIN`.
- `IDLE` + `start`, `count > 0`: go to `ISSUE` with pointer 0 and hold counter 0.
- `IDLE` + `start`, `count == 0`: go to `FIN`. No command is issued.
- `ISSUE`: drive entry[pointer] on the bus for exactly `HOLD_CYCLES` cycles, then advance the pointer.
  - After the last entry, go to `ENABLE` (macro) or `FIN`.
- `ENABLE`: drive `action=6`, `mindex=0`, `index=0`, `din=zero-extended enable_mask` for `HOLD_CYCLES` cycles, then go to `FIN`.
- `FIN`: drive `action=0`, pulse `done` for one cycle, then go to `IDLE`.
- Outside `ISSUE` and `ENABLE`, the bus is held at `action=0`, `index=0`, `mindex=0`, `din=0`.
- Stored commands with `cmd_action=0` are replayed as idle gaps of `HOLD_CYCLES` cycles.
- `start` while `busy` is ignored.
- `clear` in `IDLE` sets `count` to 0.
- `clear` while `busy`:
  - the next cycle returns to `IDLE` with `action=0` and `count=0`;
  - no `done` pulse is produced.
- `clear` and `start` in the same cycle: `clear` wins and the buffer is emptied.
- Writes are refused when `count == CMD_DEPTH`. `count` saturates and the buffer never wraps.

## Timing
- Reset values: `action=0`, `index=0`, `mindex=0`, `din=0`, `busy=0`, `done=0`, `count=0`, `cmd_ready=1`. FSM is in `IDLE`.
- All bus outputs are registered.
- `start` sampled in cycle t puts entry 0 on the bus in cycle t+1. `busy` goes high in t+1.
- Total replay of N commands:
  - N·HOLD_CYCLES bus cycles;
  - +HOLD_CYCLES with the macro;
  - then `FIN` takes one cycle with `done=1` and `busy=1`;
  - `busy` falls the cycle after `FIN`.
- Commands are issued back-to-back with no idle cycle between entries.
- Reset mid-replay: the next cycle shows reset values and the buffer is emptied.

## Configuration
- Macro `PIO_CFG_AUTO_ENABLE_EN`.
- Defined: the `enable_mask` port exists. The `ENABLE` state appends one enable command after the stored list on every replay, including a replay with `count==0`.
- Undefined: no `enable_mask` port and no `ENABLE` state. Enable must be stored as an ordinary command.

## Structure
- Package `pio_cfg_pkg`:
  - action code constants: `ACT_NONE=0`, `ACT_INSTR=1`, `ACT_WRAP=2`, `ACT_ENABLE=6`, `ACT_CLKDIV=7`;
  - packed struct `pio_cfg_cmd_t` {action, mindex, index, din};
  - FSM state enum.
- Sub-module `pio_cfg_buf`: CMD_DEPTH×`pio_cfg_cmd_t` storage with append/clear/count and an indexed read port.
- The top level holds the FSM, hold counter and pointer.

## Test plan
- Load 4 instructions (index 0–3: 0xE081, 0xE101, 0xE000, 0x0001), then wrap (action 2, index 3), clkdiv (action 7, din 0x280) and enable (action 6, din 1). Pulse `start`, with `HOLD_CYCLES=2` and the macro off.
  - Required: each command is on the bus for exactly 2 cycles starting the cycle after `start`.
  - `done` fires at cycle 15, then `action=0`.
  - The `pio` instance toggles `gpio_out[0]`.
- Write 16 commands with `CMD_DEPTH=16` → `cmd_ready=0` and `count=16`; a 17th write is ignored.
- `start` with an empty buffer, macro on, `enable_mask=4'b0101` → `action=6`, `din=5` for `HOLD_CYCLES`, then a `done` pulse.
- `clear` at cycle 3 of an 8-command replay → `action=0` next cycle, `busy=0`, `count=0`, no `done`.
- Replay twice → identical bus traces. `start` during `busy` has no effect.
- Assert `start` and `cmd_valid` together in `IDLE` → `cmd_ready=0`, the command is not stored, and `count` is unchanged.
